// File: rtl/arm_mc_pkg.sv
// arm_mc_pkg: shared types and encodings for the
// multicycle ARM control unit (arm_mc_controller).
package arm_mc_pkg;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    MEMADR,
    MEMREAD,
    MEMWB,
    MEMWRITE,
    EXECUTER,
    EXECUTEI,
    ALUWB,
    BRANCH
  } state_t;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam logic [1:0] SRCA_A  = 2'b00;
  localparam logic [1:0] SRCA_PC = 2'b01;

  localparam logic [1:0] SRCB_WD  = 2'b00;
  localparam logic [1:0] SRCB_IMM = 2'b01;
  localparam logic [1:0] SRCB_4   = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  localparam logic [3:0] CC_EQ = 4'b0000;
  localparam logic [3:0] CC_NE = 4'b0001;
  localparam logic [3:0] CC_CS = 4'b0010;
  localparam logic [3:0] CC_CC = 4'b0011;
  localparam logic [3:0] CC_MI = 4'b0100;
  localparam logic [3:0] CC_PL = 4'b0101;
  localparam logic [3:0] CC_VS = 4'b0110;
  localparam logic [3:0] CC_VC = 4'b0111;
  localparam logic [3:0] CC_HI = 4'b1000;
  localparam logic [3:0] CC_LS = 4'b1001;
  localparam logic [3:0] CC_GE = 4'b1010;
  localparam logic [3:0] CC_LT = 4'b1011;
  localparam logic [3:0] CC_GT = 4'b1100;
  localparam logic [3:0] CC_LE = 4'b1101;
  localparam logic [3:0] CC_AL = 4'b1110;

  function automatic logic [1:0] alu_dec(
    input logic [3:0] cmd
  );
    logic [1:0] r;
    r = ALU_ADD;
    unique case (1'b1)
      (cmd == CMD_SUB): r = ALU_SUB;
      (cmd == CMD_AND): r = ALU_AND;
      (cmd == CMD_ORR): r = ALU_ORR;
      default:          r = ALU_ADD;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/arm_mc_controller_if.sv
// Control bus between arm_mc_controller and datapath.
// MemReady exists only with ARM_MC_MEMWAIT_EN.
interface arm_mc_controller_if;
  import arm_mc_pkg::*;

  logic [31:0] Instr;
  logic [3:0]  ALUFlags;
`ifdef ARM_MC_MEMWAIT_EN
  logic        MemReady;
`endif
  logic        PCWrite;
  logic        RegWrite;
  logic        IRWrite;
  logic        MemWrite;
  logic        AdrSrc;
  logic [1:0]  RegSrc;
  logic [1:0]  ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic [1:0]  ResultSrc;
  logic [1:0]  ImmSrc;
  logic [1:0]  ALUControl;

  modport master (
`ifdef ARM_MC_MEMWAIT_EN
    input  MemReady,
`endif
    input  Instr, ALUFlags,
    output PCWrite, RegWrite, IRWrite,
    output MemWrite, AdrSrc, RegSrc,
    output ALUSrcA, ALUSrcB, ResultSrc,
    output ImmSrc, ALUControl
  );

  modport slave (
`ifdef ARM_MC_MEMWAIT_EN
    output MemReady,
`endif
    output Instr, ALUFlags,
    input  PCWrite, RegWrite, IRWrite,
    input  MemWrite, AdrSrc, RegSrc,
    input  ALUSrcA, ALUSrcB, ResultSrc,
    input  ImmSrc, ALUControl
  );

endinterface

// File: rtl/arm_mc_condlogic.sv
// arm_mc_condlogic: NZCV flags, condition evaluation,
// registered CondEx and write-enable gating.
module arm_mc_condlogic
  import arm_mc_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] cond,
  input  logic [3:0] alu_flags,
  input  logic       flag_ld,
  input  logic       cond_ld,
  input  logic       regw,
  input  logic       memw,
  input  logic       branch,
  input  logic       fetch,
  input  logic       rd15,
  output logic       reg_write,
  output logic       mem_write,
  output logic       pc_write
);

  logic [3:0] flags;
  logic       condex;
  logic       condexreg;
  logic       n, z, c, v;

  assign {n, z, c, v} = flags;

  // evaluate the instruction condition against NZCV
  always_comb begin
    condex = 1'b0;
    unique case (cond)
      CC_EQ:   condex = z;
      CC_NE:   condex = ~z;
      CC_CS:   condex = c;
      CC_CC:   condex = ~c;
      CC_MI:   condex = n;
      CC_PL:   condex = ~n;
      CC_VS:   condex = v;
      CC_VC:   condex = ~v;
      CC_HI:   condex = c & ~z;
      CC_LS:   condex = ~c | z;
      CC_GE:   condex = (n == v);
      CC_LT:   condex = (n != v);
      CC_GT:   condex = ~z & (n == v);
      CC_LE:   condex = z | (n != v);
      CC_AL:   condex = 1'b1;
      default: condex = 1'b0;
    endcase
  end

  // flags update only for executed S-suffixed ops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags <= 4'b0000;
    end else if (flag_ld && condexreg) begin
      flags <= alu_flags;
    end
  end

  // capture condition once per instruction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      condexreg <= 1'b0;
    end else if (cond_ld) begin
      condexreg <= condex;
    end
  end

  assign reg_write = rst_n & regw & condexreg;
  assign mem_write = rst_n & memw & condexreg;
  assign pc_write  = rst_n & (fetch
                   | (branch & condexreg)
                   | (regw & condexreg & rd15));

endmodule

// File: rtl/arm_mc_controller.sv
// arm_mc_controller: multicycle ARM Moore FSM + ALU decode.
// Optional ARM_MC_MEMWAIT_EN: memory states wait on MemReady.
module arm_mc_controller
  import arm_mc_pkg::*;
(
  input logic                 clk,
  input logic                 reset,
  arm_mc_controller_if.master bus
);

  state_t     state, next;
  logic [1:0] op;
  logic [3:0] cmd;
  logic       rd15;
  logic       mrdy;
  logic       irw, adrsrc, regw, memw;
  logic       branch, fetch, aluop;
  logic [1:0] srca, srcb, ressrc;
  logic [1:0] alu_ctl;
  wire        unused_instr = ^{bus.Instr[19:16],
                               bus.Instr[11:0]};

  assign op   = bus.Instr[27:26];
  assign cmd  = bus.Instr[24:21];
  assign rd15 = (bus.Instr[15:12] == 4'hF);

`ifdef ARM_MC_MEMWAIT_EN
  assign mrdy = bus.MemReady;
`else
  assign mrdy = 1'b1;
`endif

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= FETCH;
    end else begin
      state <= next;
    end
  end

  // next state and per-state control
  always_comb begin
    next   = state;
    irw    = 1'b0;
    adrsrc = 1'b0;
    regw   = 1'b0;
    memw   = 1'b0;
    branch = 1'b0;
    fetch  = 1'b0;
    aluop  = 1'b0;
    srca   = SRCA_A;
    srcb   = SRCB_WD;
    ressrc = RES_ALUOUT;
    unique case (state)
      FETCH: begin
        irw    = 1'b1;
        fetch  = 1'b1;
        srca   = SRCA_PC;
        srcb   = SRCB_4;
        ressrc = RES_ALURES;
        if (mrdy) next = DECODE;
      end
      DECODE: begin
        srca   = SRCA_PC;
        srcb   = SRCB_4;
        ressrc = RES_ALURES;
        unique case (op)
          OP_DP:   next = bus.Instr[25] ? EXECUTEI
                                        : EXECUTER;
          OP_MEM:  next = MEMADR;
          OP_BR:   next = BRANCH;
          default: next = FETCH;
        endcase
      end
      MEMADR: begin
        srcb = SRCB_IMM;
        next = bus.Instr[20] ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        adrsrc = 1'b1;
        if (mrdy) next = MEMWB;
      end
      MEMWB: begin
        ressrc = RES_DATA;
        regw   = 1'b1;
        next   = FETCH;
      end
      MEMWRITE: begin
        adrsrc = 1'b1;
        memw   = 1'b1;
        if (mrdy) next = FETCH;
      end
      EXECUTER: begin
        aluop = 1'b1;
        next  = ALUWB;
      end
      EXECUTEI: begin
        aluop = 1'b1;
        srcb  = SRCB_IMM;
        next  = ALUWB;
      end
      ALUWB: begin
        regw = 1'b1;
        next = FETCH;
      end
      BRANCH: begin
        srcb   = SRCB_IMM;
        ressrc = RES_ALURES;
        branch = 1'b1;
        next   = FETCH;
      end
      default: next = FETCH;
    endcase
  end

  // ALU op from cmd only in execute states
  always_comb begin
    alu_ctl = ALU_ADD;
    if (aluop) alu_ctl = alu_dec(cmd);
  end

  arm_mc_condlogic u_cond (
    .clk       (clk),
    .rst_n     (reset),
    .cond      (bus.Instr[31:28]),
    .alu_flags (bus.ALUFlags),
    .flag_ld   (aluop & bus.Instr[20]),
    .cond_ld   (state == DECODE),
    .regw      (regw),
    .memw      (memw),
    .branch    (branch),
    .fetch     (fetch),
    .rd15      (rd15),
    .reg_write (bus.RegWrite),
    .mem_write (bus.MemWrite),
    .pc_write  (bus.PCWrite)
  );

  assign bus.IRWrite    = irw & reset;
  assign bus.AdrSrc     = adrsrc;
  assign bus.RegSrc     = {op == OP_MEM, op == OP_BR};
  assign bus.ALUSrcA    = srca;
  assign bus.ALUSrcB    = srcb;
  assign bus.ResultSrc  = ressrc;
  assign bus.ImmSrc     = op;
  assign bus.ALUControl = alu_ctl;

endmodule

// File: tb/tb_arm_mc_controller.sv
// tb_arm_mc_controller: scoreboard bench for arm_mc_controller.
// Build with ARM_MC_MEMWAIT_EN to add the MemReady stall test.
module tb_arm_mc_controller;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad = 0;
  logic [3:0] mflags;

  always #5 clk = ~clk;

  arm_mc_controller_if bus();

  arm_mc_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  wire [16:0] ov = {bus.PCWrite, bus.RegWrite,
                    bus.IRWrite, bus.MemWrite,
                    bus.AdrSrc, bus.RegSrc,
                    bus.ALUSrcA, bus.ALUSrcB,
                    bus.ResultSrc, bus.ImmSrc,
                    bus.ALUControl};

  typedef enum {F, D, MA, MR, MWB, MW, XR, XI, AW, BR} st_e;
  typedef struct {
    logic [16:0] v;
    string       tag;
  } sb_t;
  sb_t sb[$];

  function automatic logic [16:0] mk(
    input logic pcw, rw, irw, mw, adr,
    input logic [1:0] rsrc, sa, sbs, rs, imm, alu
  );
    return {pcw, rw, irw, mw, adr, rsrc,
            sa, sbs, rs, imm, alu};
  endfunction

  function automatic logic cond_ok(
    input logic [3:0] c,
    input logic [3:0] f
  );
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return cy;
      4'h3: return !cy;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return cy && !z;
      4'h9: return !cy || z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [16:0] exp_for(
    input st_e st,
    input logic [31:0] ins,
    input logic cx
  );
    logic [1:0] op, rsrc, alu;
    logic rd15;
    op   = ins[27:26];
    rsrc = {op == 2'b01, op == 2'b10};
    rd15 = ins[15:12] == 4'hF;
    case (ins[24:21])
      4'b0100: alu = 2'b00;
      4'b0010: alu = 2'b01;
      4'b0000: alu = 2'b10;
      4'b1100: alu = 2'b11;
      default: alu = 2'b00;
    endcase
    case (st)
      F:   return mk(1, 0, 1, 0, 0, rsrc, 2'b01, 2'b10, 2'b10, op, 2'b00);
      D:   return mk(0, 0, 0, 0, 0, rsrc, 2'b01, 2'b10, 2'b10, op, 2'b00);
      MA:  return mk(0, 0, 0, 0, 0, rsrc, 2'b00, 2'b01, 2'b00, op, 2'b00);
      MR:  return mk(0, 0, 0, 0, 1, rsrc, 2'b00, 2'b00, 2'b00, op, 2'b00);
      MWB: return mk(cx & rd15, cx, 0, 0, 0, rsrc, 2'b00, 2'b00, 2'b01, op, 2'b00);
      MW:  return mk(0, 0, 0, cx, 1, rsrc, 2'b00, 2'b00, 2'b00, op, 2'b00);
      XR:  return mk(0, 0, 0, 0, 0, rsrc, 2'b00, 2'b00, 2'b00, op, alu);
      XI:  return mk(0, 0, 0, 0, 0, rsrc, 2'b00, 2'b01, 2'b00, op, alu);
      AW:  return mk(cx & rd15, cx, 0, 0, 0, rsrc, 2'b00, 2'b00, 2'b00, op, 2'b00);
      default: return mk(cx, 0, 0, 0, 0, rsrc, 2'b00, 2'b01, 2'b10, op, 2'b00);
    endcase
  endfunction

  task automatic drain();
    sb_t e;
    while (sb.size() > 0) begin
      @(negedge clk);
      e = sb.pop_front();
      total++;
      if (ov !== e.v) begin
        bad++;
        $display("FAIL %s: got %05h want %05h", e.tag, ov, e.v);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_seq(
    input string nm,
    input logic [31:0] ins,
    input logic cx,
    input st_e seq[$]
  );
    foreach (seq[i])
      sb.push_back('{v: exp_for(seq[i], ins, cx),
                     tag: $sformatf("%s.c%0d", nm, i)});
  endtask

  task automatic run_instr(
    input string nm,
    input logic [31:0] ins,
    input logic [3:0] af
  );
    st_e seq[$];
    logic cx;
    cx = cond_ok(ins[31:28], mflags);
    seq.push_back(F);
    seq.push_back(D);
    case (ins[27:26])
      2'b00: begin
        seq.push_back(ins[25] ? XI : XR);
        seq.push_back(AW);
      end
      2'b01: begin
        seq.push_back(MA);
        if (ins[20]) begin
          seq.push_back(MR);
          seq.push_back(MWB);
        end else begin
          seq.push_back(MW);
        end
      end
      2'b10: seq.push_back(BR);
      default: ;
    endcase
    push_seq(nm, ins, cx, seq);
    bus.Instr = ins;
    bus.ALUFlags = af;
    drain();
    if (ins[27:26] == 2'b00 && ins[20] && cx) mflags = af;
  endtask

  task automatic test_reset();
    logic [16:0] rv;
    reset = 1'b0;
    bus.Instr = 32'hE2821005;
    bus.ALUFlags = 4'h0;
    mflags = 4'h0;
    rv = exp_for(F, 32'hE2821005, 1'b0) & 17'h01FFF;
    repeat (2) begin
      @(negedge clk);
      total++;
      if (ov !== rv) begin
        bad++;
        $display("FAIL reset_out: got %05h want %05h", ov, rv);
      end
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_dp();
    run_instr("ADDI", 32'hE2821005, 4'h0);
    run_instr("ADDR", 32'hE0821003, 4'h0);
    run_instr("SUBR", 32'hE0421003, 4'h0);
    run_instr("ANDR", 32'hE0021003, 4'h0);
    run_instr("ORRR", 32'hE1821003, 4'h0);
    run_instr("EORR", 32'hE0221003, 4'h0);
    run_instr("ADDPC", 32'hE282F004, 4'h0);
  endtask

  task automatic test_flags();
    run_instr("SUBS", 32'hE0533003, 4'b0100);
    run_instr("BEQ", 32'h0A000002, 4'b1011);
    run_instr("BNE", 32'h1A000002, 4'b1011);
    run_instr("ADDNE", 32'h12821005, 4'b0000);
    run_instr("ADDNES", 32'h12921005, 4'b0000);
    run_instr("BEQ2", 32'h0A000002, 4'b0000);
  endtask

  task automatic test_cond_codes();
    logic [3:0] fv [3];
    fv[0] = 4'b1001;
    fv[1] = 4'b0110;
    fv[2] = 4'b0010;
    for (int k = 0; k < 3; k++) begin
      run_instr($sformatf("ADDS%0d", k), 32'hE2921005, fv[k]);
      for (int c = 0; c < 16; c++)
        run_instr($sformatf("B%0d_%0d", k, c),
                  {c[3:0], 28'hA000002}, 4'hF);
    end
  endtask

  task automatic test_mem();
    run_instr("LDR", 32'hE5904008, 4'h0);
    run_instr("STR", 32'hE5804008, 4'h0);
    run_instr("LDRPC", 32'hE590F008, 4'h0);
    run_instr("ADDS_Z0", 32'hE2921005, 4'b0000);
    run_instr("STREQ", 32'h05804008, 4'h0);
    run_instr("ILL", 32'hEC000000, 4'h0);
  endtask

  task automatic test_reset_mid();
    st_e seq[$];
    logic [16:0] rv;
    run_instr("SUBSz", 32'hE0533003, 4'b0100);
    seq.push_back(F);
    seq.push_back(D);
    seq.push_back(MA);
    push_seq("LDRr", 32'hE5904008, 1'b1, seq);
    bus.Instr = 32'hE5904008;
    drain();
    #2;
    total++;
    if (ov !== exp_for(MR, 32'hE5904008, 1'b1)) begin
      bad++;
      $display("FAIL mid_memread: got %05h want %05h",
               ov, exp_for(MR, 32'hE5904008, 1'b1));
    end
    reset = 1'b0;
    rv = exp_for(F, 32'hE5904008, 1'b0) & 17'h01FFF;
    #1;
    total++;
    if (ov !== rv) begin
      bad++;
      $display("FAIL mid_rst_now: got %05h want %05h", ov, rv);
    end
    @(negedge clk);
    total++;
    if (ov !== rv) begin
      bad++;
      $display("FAIL mid_rst_hold: got %05h want %05h", ov, rv);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    mflags = 4'b0000;
    run_instr("BEQr", 32'h0A000002, 4'h0);
    run_instr("BNEr", 32'h1A000002, 4'h0);
  endtask

`ifdef ARM_MC_MEMWAIT_EN
  task automatic test_memwait();
    logic [16:0] fv;
    bus.MemReady = 1'b0;
    bus.Instr = 32'hE2821005;
    fv = exp_for(F, 32'hE2821005, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (ov !== fv) begin
        bad++;
        $display("FAIL stall%0d: got %05h want %05h", i, ov, fv);
      end
      @(posedge clk);
      #1;
    end
    bus.MemReady = 1'b1;
    run_instr("ADDw", 32'hE2821005, 4'h0);
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
`ifdef ARM_MC_MEMWAIT_EN
    bus.MemReady = 1'b1;
`endif
    test_reset();
    test_dp();
    test_flags();
    test_cond_codes();
    test_mem();
    test_reset_mid();
`ifdef ARM_MC_MEMWAIT_EN
    test_memwait();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/arm_mc_controller.md
# arm_mc_controller

Multicycle control unit for the ARM datapath. Decodes the instruction held in the datapath's instruction register and walks a Moore state machine through fetch, decode, execute, memory and writeback. Drives every datapath mux select and write enable, and evaluates ARM condition codes against an internal NZCV flag register. Sits beside `datapath`: consumes `Instr` and `ALUFlags`, produces the datapath control bus plus `MemWrite` to memory.

## Interface
- No parameters.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous reset, active-low (asserted at 0).
- `Instr`  in  32  current instruction (IR output).
- `ALUFlags`  in  4  {N,Z,C,V} from datapath ALU.
- `MemReady`  in  1  memory done (present only with `ARM_MC_MEMWAIT_EN`).
- `PCWrite`, `RegWrite`, `IRWrite`, `MemWrite`  out  1 each  write enables.
- `AdrSrc`  out  1  0=PC, 1=Result.
- `RegSrc`  out  2  [0]=RA1 is R15 (branch), [1]=RA2 is Rd (memory).
- `ALUSrcA`  out  2  00=A, 01=PC.
- `ALUSrcB`  out  2  00=WriteData, 01=ExtImm, 10=constant 4.
- `ResultSrc`  out  2  00=ALUOut, 01=Data, 10=ALUResult.
- `ImmSrc`  out  2  equal to `Instr[27:26]`.
- `ALUControl`  out  2  00 ADD, 01 SUB, 10 AND, 11 ORR.

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BRANCH.
- FETCH: IRWrite=1, AdrSrc=0, SrcA=PC, SrcB=4, ADD, ResultSrc=10, PC write (unconditional).
- DECODE: SrcA=PC, SrcB=4, ADD, ResultSrc=10. Branch on Op=`Instr[27:26]`:
  - 00 with Funct[5]=0 → EXECUTER; 00 with Funct[5]=1 → EXECUTEI.
  - 01 → MEMADR.
  - 10 → BRANCH.
  - 11 → FETCH (illegal, no side effects).
- MEMADR: SrcA=A, SrcB=ExtImm, ADD. Funct[0]=1 → MEMREAD; 0 → MEMWRITE.
- MEMREAD: AdrSrc=1, ResultSrc=00 → MEMWB.
- MEMWB: ResultSrc=01, RegW → FETCH.
- MEMWRITE: AdrSrc=1, ResultSrc=00, MemW → FETCH.
- EXECUTER / EXECUTEI: SrcA=A, SrcB=WriteData or ExtImm, ALUOp → ALUWB.
- ALUWB: ResultSrc=00, RegW → FETCH.
- BRANCH: SrcA=A (R15 via RegSrc[0]), SrcB=ExtImm, ADD, ResultSrc=10, Branch → FETCH.
- ALU decode (ALUOp states only): cmd=`Instr[24:21]`. 0100→00, 0010→01, 0000→10, 1100→11, any other→00. Non-ALUOp states always use ADD.
- Conditions:
  - CondEx: combinational ARM condition evaluation (EQ..AL, all 15 codes; 1111 is false) of `Instr[31:28]` against the Flags register.
  - CondExReg: loaded in DECODE.
  - Flags register: loaded at the end of EXECUTER/EXECUTEI when S=`Instr[20]`=1 and CondExReg=1.
- Output gating:
  - RegWrite = RegW & CondExReg.
  - MemWrite = MemW & CondExReg.
  - PCWrite = FETCH | (Branch & CondExReg) | (RegW & CondExReg & Rd==15).
- Reset:
  - state=FETCH, Flags=0000, CondExReg=0.
  - While `reset`=0, all four write enables are forced to 0 and other outputs carry FETCH encodings.
  - Reset asserted mid-instruction abandons it; no partial writes occur after assertion.

## Timing
- Outputs are Moore (state plus IR fields), valid the whole cycle.
- Cycles per instruction: B 3, data-processing 4, STR 4, LDR 5, illegal 2.
- Flags written at the end of execute are visible to CondEx on the next instruction's DECODE.
- Flag updates never affect the current instruction's writeback, because CondExReg is registered.
- With MEMWAIT: FETCH, MEMREAD and MEMWRITE hold until MemReady=1.
  - While held, IRWrite and PCWrite stay asserted in FETCH.
  - While held, MemWrite stays asserted in MEMWRITE; the datapath must tolerate repeated writes of identical data.

## Configuration
- `ARM_MC_MEMWAIT_EN` defined:
  - `MemReady` port exists.
  - FETCH, MEMREAD and MEMWRITE advance only when MemReady=1.
- Undefined:
  - No `MemReady` port.
  - Memory is single-cycle and every state advances unconditionally.

## Structure
- Package `arm_mc_pkg` holds:
  - State enum.
  - ALUControl codes.
  - ALUSrcA/ALUSrcB/ResultSrc encodings.
  - Op and cmd constants.
  - Condition-code constants.
- Sub-module `arm_mc_condlogic` holds the Flags register, the CondEx evaluator, CondExReg and the RegWrite/MemWrite/PCWrite gating.
- The FSM and ALU decode stay in the top.

## Test plan
- ADD R1,R2,#5 (0xE2821005) → states FETCH, DECODE, EXECUTEI, ALUWB; ALUControl=00 in EXECUTEI; RegWrite=1 only in ALUWB.
- SUBS R3,R3,R3 (0xE0533003) with ALUFlags=0100 → Flags=0100. Then BEQ (0x0A000002) → PCWrite=1 in BRANCH; BNE (0x1A000002) → PCWrite=0 in BRANCH.
- LDR R4,[R0,#8] (0xE5904008) → 5 cycles, AdrSrc=1 in MEMREAD, ResultSrc=01 and RegWrite=1 in MEMWB. STR (0xE5804008) → MemWrite=1 only in MEMWRITE.
- ADDNE with Z=1 (0x12821005) → RegWrite=0 in ALUWB, Flags unchanged. ADD PC,... (0xE282F004) → PCWrite=1 in ALUWB.
- `reset`=0 during MEMREAD → next state FETCH, all enables 0 during reset, Flags=0000.
- With `ARM_MC_MEMWAIT_EN`: MemReady low 3 cycles in FETCH → 3 stall cycles, then DECODE on the first MemReady=1 edge.
